mlp_classifier_seq: RTL and testbench
=====================================

MLP_CLASSIFIER_SEQ -- requirements
Module: mlp_classifier_seq

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 784, meaning binary input vector length.
REQ-002 SHALL have parameter NUM_NEURONS, default 10, meaning number of output classes.
REQ-003 SHALL have parameter CHUNK_WIDTH, default 32, meaning input bits processed per cycle.
REQ-004 SHALL have derived localparams NUM_CHUNKS = ceil(INPUT_SIZE/CHUNK_WIDTH), POP_WIDTH = $clog2(INPUT_SIZE+1), IDX_WIDTH = max(1,$clog2(NUM_NEURONS)), ADDR_WIDTH = max(1,$clog2(NUM_NEURONS*NUM_CHUNKS)).
REQ-005 SHALL have ports: clk in 1 (one clock); rst in 1 (reset, synchronous, active-high).
REQ-006 SHALL have ports: in_valid in 1; in_ready out 1; in_vector in INPUT_SIZE (sample).
REQ-007 SHALL have ports: weight_addr out ADDR_WIDTH; weight_data in CHUNK_WIDTH (combinational ROM, valid in the same cycle as weight_addr).
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_class out IDX_WIDTH; out_score out POP_WIDTH.

Function
REQ-009 SHALL implement FSM IDLE -> ACCUM -> DONE -> IDLE.
REQ-010 SHALL assert in_ready only in IDLE; on in_valid&&in_ready, SHALL latch in_vector, clear neuron/chunk counters, accumulator, best score and best index, then enter ACCUM.
REQ-011 SHALL, in ACCUM, drive weight_addr = neuron*NUM_CHUNKS + chunk; weight bit j of chunk c corresponds to input bit c*CHUNK_WIDTH+j.
REQ-012 SHALL add popcount(~(in_chunk ^ weight_data)) to the accumulator each ACCUM cycle; bit positions >= INPUT_SIZE in the last chunk SHALL be masked and not counted.
REQ-013 SHALL, on the last chunk of a neuron, compare the completed score (including that cycle's chunk) against the best score; strictly greater replaces best score and index; ties keep the lower index.
REQ-014 SHALL initialise the best score from neuron 0 unconditionally, so out_class is 0 when every score is 0.
REQ-015 SHALL enter DONE the cycle after the last chunk of neuron NUM_NEURONS-1; latency from accept to out_valid = NUM_NEURONS*NUM_CHUNKS+1 cycles.
REQ-016 SHALL, in DONE, hold out_valid=1 with out_class/out_score stable until out_ready; on out_valid&&out_ready, return to IDLE next cycle.
REQ-017 SHALL ignore in_valid outside IDLE; in_vector changes after acceptance SHALL NOT affect the result.
REQ-018 SHALL size the accumulator to POP_WIDTH with no overflow (max INPUT_SIZE).
REQ-019 SHALL drive weight_addr to 0 outside ACCUM.

Reset
REQ-020 SHALL, on rst sampled high at a clk edge, force IDLE, in_ready=1 the following cycle, out_valid=0, out_class=0, out_score=0, weight_addr=0, all counters and the accumulator 0.
REQ-021 SHALL abort any in-flight ACCUM or DONE on reset with no partial result emitted; rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-022 SHALL, with MLP_CLASSIFIER_SCORES_EN defined, add port out_scores out NUM_NEURONS*POP_WIDTH holding neuron n's score at [n*POP_WIDTH +: POP_WIDTH], reset to 0, valid with out_valid.
REQ-023 SHALL, without MLP_CLASSIFIER_SCORES_EN, omit out_scores and its storage; all other behaviour identical.

Structure
REQ-024 SHALL place the FSM state enum (IDLE, ACCUM, DONE) and the width-helper functions in shared package mlp_pkg.
REQ-025 SHALL implement the masked XNOR-popcount of one chunk as combinational sub-module mlp_xnor_popcount (params CHUNK_WIDTH, VALID_BITS).

Verification (INPUT_SIZE=20, NUM_NEURONS=4, CHUNK_WIDTH=8, NUM_CHUNKS=3)
REQ-026 SHALL cover: weights equal to input for neuron 2 only, others inverted -> out_class=2, out_score=20, out_valid 13 cycles after accept.
REQ-027 SHALL cover: all-zero input, all-one weights -> scores all 0, out_class=0, out_score=0; padding bits 20..23 of chunk 2 not counted.
REQ-028 SHALL cover: neurons 1 and 3 both score 15, others lower -> out_class=1 (tie keeps lower index).
REQ-029 SHALL cover: out_ready held low 5 cycles in DONE -> out_valid, out_class, out_score stable; in_ready=0 throughout; in_valid pulses ignored.
REQ-030 SHALL cover: rst asserted at ACCUM cycle 6 -> next cycle IDLE, out_valid=0, weight_addr=0; new sample then produces a correct result.
REQ-031 SHALL cover with MLP_CLASSIFIER_SCORES_EN: scores {5,12,20,0} -> out_scores fields match, out_class=2.

Source files
------------

// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
// Shared definitions for the sequential binary MLP classifier:
//   - mlp_state_e : controller states (IDLE, ACCUM, DONE)
//   - ceil_div    : integer ceiling division for chunk counts
//   - clog2_min1  : $clog2 clamped to at least one bit, for index/address ports
// No ports (package).
// -----------------------------------------------------------------------------
package mlp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } mlp_state_e;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // A zero-width index is not representable, so single-entry ranges get 1 bit.
   function automatic int clog2_min1(input int value);
      int bits;
      bits = $clog2(value);
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/mlp_xnor_popcount.sv
// -----------------------------------------------------------------------------
// mlp_xnor_popcount
// Combinational XNOR-popcount of one input chunk against one weight chunk.
// Only the low VALID_BITS positions are counted; higher positions are padding
// beyond the end of the input vector and never contribute.
// Ports:
//   in_chunk     in  CHUNK_WIDTH  input bits of the current chunk
//   weight_chunk in  CHUNK_WIDTH  weight bits of the current chunk
//   count        out CNT_WIDTH    number of matching valid bit positions
// -----------------------------------------------------------------------------
module mlp_xnor_popcount
   import mlp_pkg::*;
#(
   parameter  int CHUNK_WIDTH = 32,
   parameter  int VALID_BITS  = 32,
   localparam int CNT_WIDTH   = $clog2(CHUNK_WIDTH + 1)
) (
   input  logic [CHUNK_WIDTH-1:0] in_chunk,
   input  logic [CHUNK_WIDTH-1:0] weight_chunk,
   output logic [CNT_WIDTH-1:0]   count
);

   logic [CHUNK_WIDTH-1:0] match_s;

   // Count matching bits, skipping positions beyond VALID_BITS.
   always_comb begin
      match_s = ~(in_chunk ^ weight_chunk);
      count   = '0;
      for (int j = 0; j < CHUNK_WIDTH; j++) begin
         if (j < VALID_BITS) begin
            count = count + CNT_WIDTH'(match_s[j]);
         end else begin
            count = count;
         end
      end
   end

endmodule

// File: rtl/mlp_classifier_seq.sv
// -----------------------------------------------------------------------------
// mlp_classifier_seq
// Sequential single-layer binary (XNOR-popcount) classifier. A sample is
// accepted in IDLE, then every neuron's score is accumulated one weight chunk
// per cycle from an external combinational weight ROM. The highest-scoring
// neuron (lowest index on ties) is presented on out_class/out_score in DONE
// until the consumer accepts it.
// Ports:
//   clk, rst      one clock; synchronous active-high reset
//   in_valid/in_ready/in_vector      sample input handshake
//   weight_addr/weight_data          ROM address (neuron*NUM_CHUNKS+chunk), data same cycle
//   out_valid/out_ready/out_class/out_score   result handshake
//   out_scores    (only with MLP_CLASSIFIER_SCORES_EN) all neuron scores,
//                 neuron n at [n*POP_WIDTH +: POP_WIDTH]
// Build option: define MLP_CLASSIFIER_SCORES_EN to add out_scores.
// -----------------------------------------------------------------------------
module mlp_classifier_seq
   import mlp_pkg::*;
#(
   parameter  int INPUT_SIZE  = 784,
   parameter  int NUM_NEURONS = 10,
   parameter  int CHUNK_WIDTH = 32,
   localparam int NUM_CHUNKS  = ceil_div(INPUT_SIZE, CHUNK_WIDTH),
   localparam int POP_WIDTH   = $clog2(INPUT_SIZE + 1),
   localparam int IDX_WIDTH   = clog2_min1(NUM_NEURONS),
   localparam int ADDR_WIDTH  = clog2_min1(NUM_NEURONS * NUM_CHUNKS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_SIZE-1:0]  in_vector,
   output logic [ADDR_WIDTH-1:0]  weight_addr,
   input  logic [CHUNK_WIDTH-1:0] weight_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IDX_WIDTH-1:0]   out_class,
   output logic [POP_WIDTH-1:0]   out_score
`ifdef MLP_CLASSIFIER_SCORES_EN
   ,
   output logic [NUM_NEURONS*POP_WIDTH-1:0] out_scores
`endif
);

   localparam int CIDX_WIDTH = clog2_min1(NUM_CHUNKS);
   localparam int PAD_WIDTH  = NUM_CHUNKS * CHUNK_WIDTH;
   localparam int LAST_BITS  = INPUT_SIZE - (NUM_CHUNKS - 1) * CHUNK_WIDTH;
   localparam int CNT_WIDTH  = $clog2(CHUNK_WIDTH + 1);

   mlp_state_e              state_q, state_d;
   logic [PAD_WIDTH-1:0]    vec_q, vec_d;
   logic [IDX_WIDTH-1:0]    neuron_q, neuron_d;
   logic [CIDX_WIDTH-1:0]   chunk_q, chunk_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [POP_WIDTH-1:0]    acc_q, acc_d;
   logic [POP_WIDTH-1:0]    best_score_q, best_score_d;
   logic [IDX_WIDTH-1:0]    best_idx_q, best_idx_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
`ifdef MLP_CLASSIFIER_SCORES_EN
   logic [NUM_NEURONS*POP_WIDTH-1:0] scores_q, scores_d;
`endif

   logic [CHUNK_WIDTH-1:0]  in_chunk_s;
   logic [CNT_WIDTH-1:0]    pop_full_s;
   logic [CNT_WIDTH-1:0]    pop_last_s;
   logic [CNT_WIDTH-1:0]    pop_s;
   logic [POP_WIDTH-1:0]    sum_s;
   logic                    last_chunk_s;
   logic                    last_neuron_s;

   // The latched vector is zero-extended to whole chunks, so slicing never
   // runs past its end; the padding is discarded by the last-chunk counter.
   assign in_chunk_s    = vec_q[int'(chunk_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
   assign last_chunk_s  = (chunk_q == CIDX_WIDTH'(NUM_CHUNKS - 1));
   assign last_neuron_s = (neuron_q == IDX_WIDTH'(NUM_NEURONS - 1));

   mlp_xnor_popcount #(
      .CHUNK_WIDTH (CHUNK_WIDTH),
      .VALID_BITS  (CHUNK_WIDTH)
   ) u_pop_full (
      .in_chunk     (in_chunk_s),
      .weight_chunk (weight_data),
      .count        (pop_full_s)
   );

   mlp_xnor_popcount #(
      .CHUNK_WIDTH (CHUNK_WIDTH),
      .VALID_BITS  (LAST_BITS)
   ) u_pop_last (
      .in_chunk     (in_chunk_s),
      .weight_chunk (weight_data),
      .count        (pop_last_s)
   );

   assign pop_s = last_chunk_s ? pop_last_s : pop_full_s;
   // Score including this cycle's chunk; POP_WIDTH holds up to INPUT_SIZE.
   assign sum_s = acc_q + POP_WIDTH'(pop_s);

   // Next-state, counter, accumulator and best-score logic.
   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      neuron_d     = neuron_q;
      chunk_d      = chunk_q;
      addr_d       = addr_q;
      acc_d        = acc_q;
      best_score_d = best_score_q;
      best_idx_d   = best_idx_q;
`ifdef MLP_CLASSIFIER_SCORES_EN
      scores_d     = scores_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               vec_d        = PAD_WIDTH'(in_vector);
               neuron_d     = '0;
               chunk_d      = '0;
               addr_d       = '0;
               acc_d        = '0;
               best_score_d = '0;
               best_idx_d   = '0;
`ifdef MLP_CLASSIFIER_SCORES_EN
               scores_d     = '0;
`endif
               state_d      = ACCUM;
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM: begin
            addr_d = addr_q + ADDR_WIDTH'(1'b1);
            if (last_chunk_s) begin
               acc_d   = '0;
               chunk_d = '0;
               // Neuron 0 seeds the best score so an all-zero run reports class 0.
               if ((neuron_q == '0) || (sum_s > best_score_q)) begin
                  best_score_d = sum_s;
                  best_idx_d   = neuron_q;
               end else begin
                  best_score_d = best_score_q;
               end
`ifdef MLP_CLASSIFIER_SCORES_EN
               scores_d[int'(neuron_q) * POP_WIDTH +: POP_WIDTH] = sum_s;
`endif
               if (last_neuron_s) begin
                  neuron_d = '0;
                  addr_d   = '0;
                  state_d  = DONE;
               end else begin
                  neuron_d = neuron_q + IDX_WIDTH'(1'b1);
               end
            end else begin
               acc_d   = sum_s;
               chunk_d = chunk_q + CIDX_WIDTH'(1'b1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Handshake flags are registered copies of the upcoming state.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         vec_q        <= '0;
         neuron_q     <= '0;
         chunk_q      <= '0;
         addr_q       <= '0;
         acc_q        <= '0;
         best_score_q <= '0;
         best_idx_q   <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
`ifdef MLP_CLASSIFIER_SCORES_EN
         scores_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         neuron_q     <= neuron_d;
         chunk_q      <= chunk_d;
         addr_q       <= addr_d;
         acc_q        <= acc_d;
         best_score_q <= best_score_d;
         best_idx_q   <= best_idx_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
`ifdef MLP_CLASSIFIER_SCORES_EN
         scores_q     <= scores_d;
`endif
      end
   end

   assign in_ready    = in_ready_q;
   assign weight_addr = addr_q;
   assign out_valid   = out_valid_q;
   assign out_class   = best_idx_q;
   assign out_score   = best_score_q;
`ifdef MLP_CLASSIFIER_SCORES_EN
   assign out_scores  = scores_q;
`endif

endmodule

// File: tb/tb_mlp_classifier_seq.sv
// -----------------------------------------------------------------------------
// tb_mlp_classifier_seq
// Directed bench for mlp_classifier_seq with INPUT_SIZE=20, NUM_NEURONS=4,
// CHUNK_WIDTH=8 (3 chunks). Each neuron's weights are built from the sample by
// inverting its lowest (20 - target) bits, so each neuron's score is exactly
// the chosen target. Define MLP_CLASSIFIER_SCORES_EN to also check out_scores.
// -----------------------------------------------------------------------------
module tb_mlp_classifier_seq;

   localparam int AW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_vector;
   logic [3:0]  weight_addr;
   logic [7:0]  weight_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_class;
   logic [4:0]  out_score;
`ifdef MLP_CLASSIFIER_SCORES_EN
   logic [19:0] out_scores;
`endif

   logic [7:0] wrom [0:11];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always_comb weight_data = (weight_addr < 4'd12) ? wrom[weight_addr] : 8'h00;

   mlp_classifier_seq #(
      .INPUT_SIZE  (20),
      .NUM_NEURONS (4),
      .CHUNK_WIDTH (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_vector   (in_vector),
      .weight_addr (weight_addr),
      .weight_data (weight_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_class   (out_class),
      .out_score   (out_score)
`ifdef MLP_CLASSIFIER_SCORES_EN
      ,
      .out_scores  (out_scores)
`endif
   );

   task automatic load_weights(input logic [19:0] x, input int s0, input int s1,
                               input int s2, input int s3, input logic [3:0] pad);
      int          s [4];
      logic [31:0] m;
      logic [23:0] w;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      for (int n = 0; n < 4; n++) begin
         m = (32'd1 << (20 - s[n])) - 32'd1;
         w = {pad, x ^ m[19:0]};
         for (int c = 0; c < 3; c++) wrom[n*3 + c] = w[c*8 +: 8];
      end
   endtask

   // Accepts x, scrambles in_vector afterwards, checks the address walk and
   // returns the latency (accepting edge .. first out_valid edge, inclusive).
   task automatic run_inference(input logic [19:0] x, output int lat,
                                output logic [1:0] cls, output logic [4:0] score);
      in_vector = x;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      lat       = 1;
      in_valid  = 1'b0;
      in_vector = ~x;
      while (out_valid !== 1'b1 && lat < 64) begin
         checks++;
         if (weight_addr !== AW'(lat - 1)) begin
            errors++;
            $display("FAIL weight_addr walk step %0d: got %0d expected %0d", lat - 1, weight_addr, lat - 1);
         end
         @(posedge clk); #1;
         lat++;
      end
      cls   = out_class;
      score = out_score;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_vector = 20'h0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
      checks++; if (out_class !== 2'd0) begin errors++; $display("FAIL reset out_class: got %0d expected 0", out_class); end
      checks++; if (out_score !== 5'd0) begin errors++; $display("FAIL reset out_score: got %0d expected 0", out_score); end
      checks++; if (weight_addr !== 4'd0) begin errors++; $display("FAIL reset weight_addr: got %0d expected 0", weight_addr); end
   endtask

   task automatic test_match_neuron2();
      int lat; logic [1:0] cls; logic [4:0] sc;
      load_weights(20'hA5C3F, 0, 0, 20, 0, 4'h0);
      run_inference(20'hA5C3F, lat, cls, sc);
      checks++; if (lat !== 13) begin errors++; $display("FAIL match latency: got %0d expected 13", lat); end
      checks++; if (cls !== 2'd2) begin errors++; $display("FAIL match out_class: got %0d expected 2", cls); end
      checks++; if (sc !== 5'd20) begin errors++; $display("FAIL match out_score: got %0d expected 20", sc); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL match release out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL match release in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_all_zero();
      int lat; logic [1:0] cls; logic [4:0] sc;
      // Weight padding 0 matches input padding 0: counted only if unmasked.
      load_weights(20'h00000, 0, 0, 0, 0, 4'h0);
      run_inference(20'h00000, lat, cls, sc);
      checks++; if (cls !== 2'd0) begin errors++; $display("FAIL zero out_class: got %0d expected 0", cls); end
      checks++; if (sc !== 5'd0) begin errors++; $display("FAIL zero out_score: got %0d expected 0", sc); end
      @(posedge clk); #1;
   endtask

   task automatic test_tie();
      int lat; logic [1:0] cls; logic [4:0] sc;
      load_weights(20'h3C96A, 10, 15, 7, 15, 4'h0);
      run_inference(20'h3C96A, lat, cls, sc);
      checks++; if (cls !== 2'd1) begin errors++; $display("FAIL tie out_class: got %0d expected 1", cls); end
      checks++; if (sc !== 5'd15) begin errors++; $display("FAIL tie out_score: got %0d expected 15", sc); end
      @(posedge clk); #1;
   endtask

   task automatic test_scores();
      int lat; logic [1:0] cls; logic [4:0] sc;
      load_weights(20'h5F00D, 5, 12, 20, 0, 4'h0);
      run_inference(20'h5F00D, lat, cls, sc);
      checks++; if (cls !== 2'd2) begin errors++; $display("FAIL scores out_class: got %0d expected 2", cls); end
      checks++; if (sc !== 5'd20) begin errors++; $display("FAIL scores out_score: got %0d expected 20", sc); end
`ifdef MLP_CLASSIFIER_SCORES_EN
      checks++;
      if (out_scores !== {5'd0, 5'd20, 5'd12, 5'd5}) begin
         errors++;
         $display("FAIL scores out_scores: got %h expected %h", out_scores, {5'd0, 5'd20, 5'd12, 5'd5});
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int lat; logic [1:0] cls; logic [4:0] sc;
      out_ready = 1'b0;
      load_weights(20'h0F0F0, 3, 9, 2, 18, 4'h0);
      run_inference(20'h0F0F0, lat, cls, sc);
      for (int i = 0; i < 5; i++) begin
         in_valid  = (i % 2 == 0);
         in_vector = 20'(32'($urandom));
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall %0d out_valid: got %b expected 1", i, out_valid); end
         checks++; if (out_class !== 2'd3) begin errors++; $display("FAIL stall %0d out_class: got %0d expected 3", i, out_class); end
         checks++; if (out_score !== 5'd18) begin errors++; $display("FAIL stall %0d out_score: got %0d expected 18", i, out_score); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall %0d in_ready: got %b expected 0", i, in_ready); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall release out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall release in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_reset_abort();
      int lat; logic [1:0] cls; logic [4:0] sc; int seen;
      load_weights(20'hABCDE, 1, 2, 3, 4, 4'h0);
      in_vector = 20'hABCDE;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      checks++; if (weight_addr !== 4'd6) begin errors++; $display("FAIL abort pre weight_addr: got %0d expected 6", weight_addr); end
      // Reset wins over a simultaneous input offer.
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort out_valid: got %b expected 0", out_valid); end
      checks++; if (weight_addr !== 4'd0) begin errors++; $display("FAIL abort weight_addr: got %0d expected 0", weight_addr); end
      checks++; if (out_score !== 5'd0) begin errors++; $display("FAIL abort out_score: got %0d expected 0", out_score); end
      checks++; if (out_class !== 2'd0) begin errors++; $display("FAIL abort out_class: got %0d expected 0", out_class); end
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort idle hold: got %0d busy cycles expected 0", seen); end
      load_weights(20'h12345, 7, 19, 19, 3, 4'h0);
      run_inference(20'h12345, lat, cls, sc);
      checks++; if (lat !== 13) begin errors++; $display("FAIL abort rerun latency: got %0d expected 13", lat); end
      checks++; if (cls !== 2'd1) begin errors++; $display("FAIL abort rerun out_class: got %0d expected 1", cls); end
      checks++; if (sc !== 5'd19) begin errors++; $display("FAIL abort rerun out_score: got %0d expected 19", sc); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat; logic [1:0] cls; logic [4:0] sc;
      load_weights(20'hFFFFF, 20, 0, 0, 0, 4'hF);
      run_inference(20'hFFFFF, lat, cls, sc);
      checks++; if (cls !== 2'd0) begin errors++; $display("FAIL b2b first out_class: got %0d expected 0", cls); end
      checks++; if (sc !== 5'd20) begin errors++; $display("FAIL b2b first out_score: got %0d expected 20", sc); end
      @(posedge clk); #1;
      load_weights(20'h6B2D1, 4, 8, 12, 16, 4'hF);
      run_inference(20'h6B2D1, lat, cls, sc);
      checks++; if (lat !== 13) begin errors++; $display("FAIL b2b second latency: got %0d expected 13", lat); end
      checks++; if (cls !== 2'd3) begin errors++; $display("FAIL b2b second out_class: got %0d expected 3", cls); end
      checks++; if (sc !== 5'd16) begin errors++; $display("FAIL b2b second out_score: got %0d expected 16", sc); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_match_neuron2();
      test_all_zero();
      test_tie();
      test_scores();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
